core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter MEMORY_TIMEOUT, default 16: maximum cycles to wait for any memory ready before fault.
REQ-002 SHALL have parameter RETIRE_COUNTER_WIDTH, default 32: width of the retired-instruction counter.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 instruction_memory_request  out  1  fetch request, held until ready.
REQ-007 instruction_memory_ready  in  1  fetch data valid this cycle.
REQ-008 instruction_memory_read_data  in  32  fetched instruction word.
REQ-009 instruction_register  out  32  latched current instruction.
REQ-010 data_memory_request  out  1  load/store request, held until ready.
REQ-011 data_memory_write  out  1  1 = store, 0 = load; valid with request.
REQ-012 data_memory_ready  in  1  load/store complete this cycle.
REQ-013 branch_condition  in  1  comparator result for the current branch.
REQ-014 program_counter_write  out  1  single-cycle PC update strobe.
REQ-015 program_counter_select  out  2  0 = PC+4, 1 = PC+Bimm, 2 = PC+Jimm, 3 = rs1+Iimm.
REQ-016 register_write  out  1  single-cycle register-file write strobe.
REQ-017 register_write_select  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = Uimm.
REQ-018 alu_source_select  out  1  0 = rs2, 1 = immediate.
REQ-019 fault  out  1  sticky: illegal opcode or memory timeout.
REQ-020 retired_count  out  RETIRE_COUNTER_WIDTH  instructions completed since reset.

Function
REQ-021 SHALL implement states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
REQ-022 FETCH: assert instruction_memory_request. On ready, latch instruction_memory_read_data into instruction_register and go to DECODE the next cycle.
REQ-023 DECODE: classify opcode bits [6:2] as OP 01100, OP-IMM 00100, BRANCH 11000, JAL 11011, JALR 11001, AUIPC 00101, LUI 01101, LOAD 00000, STORE 01000, SYSTEM 11100.
REQ-024 DECODE: bits [1:0] != 11 or any unlisted opcode -> set fault, go to HALT. SYSTEM -> HALT without fault. All others -> EXECUTE.
REQ-025 EXECUTE, one cycle: alu_source_select = 1 for OP-IMM, LOAD, STORE, JALR; 0 otherwise. LOAD/STORE -> MEMORY; all others -> WRITEBACK.
REQ-026 MEMORY: assert data_memory_request, with data_memory_write = 1 for STORE. Hold both stable until ready, then go to WRITEBACK.
REQ-027 WRITEBACK, one cycle, pulses program_counter_write with select: BRANCH 1 if branch_condition else 0; JAL 2; JALR 3; others 0.
REQ-028 WRITEBACK pulses register_write for OP, OP-IMM, JAL, JALR, AUIPC, LUI, LOAD with register_write_select 0, 0, 2, 2, 0, 3, 1 respectively. No write for BRANCH or STORE.
REQ-029 WRITEBACK SHALL suppress register_write when instruction_register[11:7] == 0.
REQ-030 WRITEBACK increments retired_count, wraps modulo 2^RETIRE_COUNTER_WIDTH, and goes to FETCH.
REQ-031 Minimum latency SHALL be 4 cycles for non-memory instructions and 5 for loads/stores, with zero-wait memory (ready in the first request cycle).
REQ-032 A wait counter SHALL count cycles with request high and ready low in FETCH or MEMORY. On reaching MEMORY_TIMEOUT: drop the request, set fault, go to HALT. The counter clears on every state change.
REQ-033 Ready arriving in the same cycle the counter reaches MEMORY_TIMEOUT SHALL count as success, not fault.
REQ-034 Ready while no request is outstanding SHALL be ignored.
REQ-035 HALT is absorbing: all strobes and requests stay low until reset.
REQ-036 program_counter_write and register_write SHALL never be high outside WRITEBACK.

Reset
REQ-037 While reset_n is low at a clock edge, the block SHALL go to FETCH and clear instruction_register, fault, retired_count and the wait counter; every output is 0.
REQ-038 Reset mid-transaction SHALL drop any outstanding request in the next cycle with no strobe issued. Fetch restarts one cycle after reset_n rises.

Structure
REQ-039 The opcode constants, the state encoding, and the program_counter_select / register_write_select codes SHALL live in the shared package wave_rv_pkg.
REQ-040 Opcode classification SHALL be one sub-module, opcode_decoder: combinational, one-hot class outputs plus an illegal flag.
REQ-041 All state-holding logic SHALL be in one clocked process.

Verification
REQ-042 Fetch 0x00500093 (addi x1,x0,5) with zero-wait memory -> register_write=1, select 0, program_counter_select 0 in cycle 4, retired_count=1.
REQ-043 Load 0x0000A103 with data ready after 3 wait cycles -> data_memory_request high for 4 cycles, data_memory_write=0, register_write select 1, retired_count=1.
REQ-044 Branch 0x00208463 with branch_condition=1 -> program_counter_select=1 and register_write=0 in WRITEBACK. Repeat with branch_condition=0 -> select 0.
REQ-045 Instruction ready never asserted -> fault=1 after exactly 16 request cycles, HALT, request low thereafter. Also ready exactly on the 16th cycle -> no fault.
REQ-046 Fetch 0xFFFFFFFF -> fault=1 and HALT after DECODE. Fetch 0x00000073 -> HALT, fault=0.
REQ-047 reset_n low during MEMORY -> data_memory_request low next cycle, outputs zero, FETCH resumes.

Source files
------------

// File: rtl/wave_rv_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, RV32I major
// opcodes, writeback mux codes and the decoded instruction-class record.
package wave_rv_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } seq_state_t;

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JAL    = 2'd2;
    localparam logic [1:0] PC_SEL_JALR   = 2'd3;

    localparam logic [1:0] RF_SEL_ALU  = 2'd0;
    localparam logic [1:0] RF_SEL_LOAD = 2'd1;
    localparam logic [1:0] RF_SEL_LINK = 2'd2;
    localparam logic [1:0] RF_SEL_UIMM = 2'd3;

    typedef struct packed {
        logic op;
        logic op_imm;
        logic branch;
        logic jal;
        logic jalr;
        logic auipc;
        logic lui;
        logic load;
        logic store;
        logic system;
    } op_class_t;

    // Classes whose second ALU operand comes from the immediate.
    function automatic logic uses_imm(input op_class_t c);
        return c.op_imm | c.load | c.store | c.jalr;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational RV32I major-opcode classifier: one-hot class plus an illegal
// flag covering both non-32-bit encodings and unlisted opcodes.
module opcode_decoder import wave_rv_pkg::*; (
    input  logic [6:0] i_opcode,
    output op_class_t  o_class,
    output logic       o_illegal
);

    // One-hot classification; the class stays all-zero whenever illegal is set.
    always_comb begin
        o_class   = '0;
        o_illegal = 1'b0;
        if (i_opcode[1:0] != 2'b11) begin
            o_illegal = 1'b1;
        end else begin
            case (i_opcode[6:2])
                OPC_OP:     o_class.op     = 1'b1;
                OPC_OP_IMM: o_class.op_imm = 1'b1;
                OPC_BRANCH: o_class.branch = 1'b1;
                OPC_JAL:    o_class.jal    = 1'b1;
                OPC_JALR:   o_class.jalr   = 1'b1;
                OPC_AUIPC:  o_class.auipc  = 1'b1;
                OPC_LUI:    o_class.lui    = 1'b1;
                OPC_LOAD:   o_class.load   = 1'b1;
                OPC_STORE:  o_class.store  = 1'b1;
                OPC_SYSTEM: o_class.system = 1'b1;
                default:    o_illegal      = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/memory/writeback
// with memory-wait timeout, sticky fault and a retired-instruction counter.
module core_sequencer import wave_rv_pkg::*; #(
    parameter int MEMORY_TIMEOUT       = 16,
    parameter int RETIRE_COUNTER_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    output logic                            instruction_memory_request,
    input  logic                            instruction_memory_ready,
    input  logic [31:0]                     instruction_memory_read_data,
    output logic [31:0]                     instruction_register,
    output logic                            data_memory_request,
    output logic                            data_memory_write,
    input  logic                            data_memory_ready,
    input  logic                            branch_condition,
    output logic                            program_counter_write,
    output logic [1:0]                      program_counter_select,
    output logic                            register_write,
    output logic [1:0]                      register_write_select,
    output logic                            alu_source_select,
    output logic                            fault,
    output logic [RETIRE_COUNTER_WIDTH-1:0] retired_count
);

    localparam int WAIT_W = $clog2(MEMORY_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEMORY_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [RETIRE_COUNTER_WIDTH-1:0] RETIRE_ONE = RETIRE_COUNTER_WIDTH'(1);

    seq_state_t                      r_state;
    logic [31:0]                     r_ir;
    logic                            r_fault;
    logic [RETIRE_COUNTER_WIDTH-1:0] r_retired;
    logic [WAIT_W-1:0]               r_wait_cnt;
    logic                            r_imem_req;
    logic                            r_dmem_req;
    logic                            r_dmem_we;
    logic                            r_pc_we;
    logic [1:0]                      r_pc_sel;
    logic                            r_rf_we;
    logic [1:0]                      r_rf_sel;
    logic                            r_alu_src;

    seq_state_t                      w_state_nxt;
    logic [31:0]                     w_ir_nxt;
    logic                            w_fault_nxt;
    logic [RETIRE_COUNTER_WIDTH-1:0] w_retired_nxt;
    logic [WAIT_W-1:0]               w_wait_nxt;
    logic                            w_imem_req_nxt;
    logic                            w_dmem_req_nxt;
    logic                            w_dmem_we_nxt;
    logic                            w_alu_src_nxt;
    logic                            w_enter_wb;

    op_class_t                       w_class;
    logic                            w_illegal;
    logic                            w_rd_nz;
    logic [1:0]                      w_wb_pc_sel;
    logic                            w_wb_rf_we;
    logic [1:0]                      w_wb_rf_sel;

    opcode_decoder u_opcode_decoder (
        .i_opcode  (r_ir[6:0]),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

    assign w_rd_nz = |r_ir[11:7];

    // Writeback payload for the latched instruction; x0 destinations never write.
    always_comb begin
        w_wb_pc_sel = PC_SEL_PLUS4;
        w_wb_rf_we  = 1'b0;
        w_wb_rf_sel = RF_SEL_ALU;
        if (w_class.branch) begin
            w_wb_pc_sel = branch_condition ? PC_SEL_BRANCH : PC_SEL_PLUS4;
        end else if (w_class.jal) begin
            w_wb_pc_sel = PC_SEL_JAL;
            w_wb_rf_we  = w_rd_nz;
            w_wb_rf_sel = RF_SEL_LINK;
        end else if (w_class.jalr) begin
            w_wb_pc_sel = PC_SEL_JALR;
            w_wb_rf_we  = w_rd_nz;
            w_wb_rf_sel = RF_SEL_LINK;
        end else if (w_class.op | w_class.op_imm | w_class.auipc) begin
            w_wb_rf_we  = w_rd_nz;
        end else if (w_class.lui) begin
            w_wb_rf_we  = w_rd_nz;
            w_wb_rf_sel = RF_SEL_UIMM;
        end else if (w_class.load) begin
            w_wb_rf_we  = w_rd_nz;
            w_wb_rf_sel = RF_SEL_LOAD;
        end else begin
            w_wb_rf_we  = 1'b0;
        end
    end

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        w_state_nxt    = r_state;
        w_ir_nxt       = r_ir;
        w_fault_nxt    = r_fault;
        w_retired_nxt  = r_retired;
        w_wait_nxt     = '0;
        w_imem_req_nxt = 1'b0;
        w_dmem_req_nxt = 1'b0;
        w_dmem_we_nxt  = 1'b0;
        w_alu_src_nxt  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // Right after reset the request is still low, so ready is ignored.
                if (r_imem_req && instruction_memory_ready) begin
                    w_ir_nxt    = instruction_memory_read_data;
                    w_state_nxt = ST_DECODE;
                end else if (r_imem_req && (r_wait_cnt == WAIT_LAST)) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_HALT;
                end else if (r_imem_req) begin
                    w_wait_nxt     = r_wait_cnt + WAIT_ONE;
                    w_imem_req_nxt = 1'b1;
                end else begin
                    w_imem_req_nxt = 1'b1;
                end
            end
            ST_DECODE: begin
                if (w_illegal) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_HALT;
                end else if (w_class.system) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt   = ST_EXECUTE;
                    w_alu_src_nxt = uses_imm(w_class);
                end
            end
            ST_EXECUTE: begin
                if (w_class.load | w_class.store) begin
                    w_state_nxt    = ST_MEMORY;
                    w_dmem_req_nxt = 1'b1;
                    w_dmem_we_nxt  = w_class.store;
                end else begin
                    w_state_nxt = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (r_dmem_req && data_memory_ready) begin
                    w_state_nxt = ST_WRITEBACK;
                end else if (r_dmem_req && (r_wait_cnt == WAIT_LAST)) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = ST_HALT;
                end else if (r_dmem_req) begin
                    w_wait_nxt     = r_wait_cnt + WAIT_ONE;
                    w_dmem_req_nxt = 1'b1;
                    w_dmem_we_nxt  = r_dmem_we;
                end else begin
                    w_dmem_req_nxt = 1'b1;
                    w_dmem_we_nxt  = w_class.store;
                end
            end
            ST_WRITEBACK: begin
                w_retired_nxt  = r_retired + RETIRE_ONE;
                w_state_nxt    = ST_FETCH;
                w_imem_req_nxt = 1'b1;
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_fault_nxt = 1'b1;
                w_state_nxt = ST_HALT;
            end
        endcase
        w_enter_wb = (w_state_nxt == ST_WRITEBACK);
    end

    // Every state-holding element, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_FETCH;
            r_ir       <= 32'd0;
            r_fault    <= 1'b0;
            r_retired  <= '0;
            r_wait_cnt <= '0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_pc_we    <= 1'b0;
            r_pc_sel   <= PC_SEL_PLUS4;
            r_rf_we    <= 1'b0;
            r_rf_sel   <= RF_SEL_ALU;
            r_alu_src  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ir       <= w_ir_nxt;
            r_fault    <= w_fault_nxt;
            r_retired  <= w_retired_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_imem_req <= w_imem_req_nxt;
            r_dmem_req <= w_dmem_req_nxt;
            r_dmem_we  <= w_dmem_we_nxt;
            r_pc_we    <= w_enter_wb;
            r_pc_sel   <= w_enter_wb ? w_wb_pc_sel : PC_SEL_PLUS4;
            r_rf_we    <= w_enter_wb & w_wb_rf_we;
            r_rf_sel   <= w_enter_wb ? w_wb_rf_sel : RF_SEL_ALU;
            r_alu_src  <= w_alu_src_nxt;
        end
    end

    assign instruction_memory_request = r_imem_req;
    assign instruction_register       = r_ir;
    assign data_memory_request        = r_dmem_req;
    assign data_memory_write          = r_dmem_we;
    assign program_counter_write      = r_pc_we;
    assign program_counter_select     = r_pc_sel;
    assign register_write             = r_rf_we;
    assign register_write_select      = r_rf_sel;
    assign alu_source_select          = r_alu_src;
    assign fault                      = r_fault;
    assign retired_count              = r_retired;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized self-checking bench for core_sequencer; expected behaviour comes
// from a per-instruction timeline built from the opcode table and memory waits.
module tb_core_sequencer;

    localparam int TIMEOUT = 16;
    localparam logic [1:0] K_RUN = 2'd0;
    localparam logic [1:0] K_ILL = 2'd1;
    localparam logic [1:0] K_SYS = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       alu;
        logic       mem;
        logic       st;
        logic       rfw;
        logic [1:0] pcs;
        logic [1:0] rfs;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic        imem_rdy;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic        dreq;
    logic        dwe;
    logic        drdy;
    logic        bc;
    logic        pcw;
    logic [1:0]  pcs;
    logic        rfw;
    logic [1:0]  rfs;
    logic        alu;
    logic        flt;
    logic [31:0] retired;

    int          n_checks = 0;
    int          n_fail   = 0;
    string       cur_test = "reset";
    logic [31:0] exp_retired = 32'd0;
    logic [31:0] prev_ir     = 32'd0;

    core_sequencer #(.MEMORY_TIMEOUT(TIMEOUT), .RETIRE_COUNTER_WIDTH(32)) dut (
        .clk                          (clk),
        .reset_n                      (reset_n),
        .instruction_memory_request   (imem_req),
        .instruction_memory_ready     (imem_rdy),
        .instruction_memory_read_data (imem_data),
        .instruction_register         (ir),
        .data_memory_request          (dreq),
        .data_memory_write            (dwe),
        .data_memory_ready            (drdy),
        .branch_condition             (bc),
        .program_counter_write        (pcw),
        .program_counter_select       (pcs),
        .register_write               (rfw),
        .register_write_select        (rfs),
        .alu_source_select            (alu),
        .fault                        (flt),
        .retired_count                (retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", cur_test, tag, got, exp, $time);
        end
    endtask

    // Reference behaviour straight from the opcode table.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic b);
        exp_t e;
        e = '0;
        if (ins[1:0] != 2'b11) begin
            e.kind = K_ILL;
        end else begin
            case (ins[6:2])
                5'b01100: begin e.rfw = 1'b1; e.rfs = 2'd0; end
                5'b00100: begin e.rfw = 1'b1; e.rfs = 2'd0; e.alu = 1'b1; end
                5'b11000: begin e.pcs = b ? 2'd1 : 2'd0; end
                5'b11011: begin e.rfw = 1'b1; e.rfs = 2'd2; e.pcs = 2'd2; end
                5'b11001: begin e.rfw = 1'b1; e.rfs = 2'd2; e.pcs = 2'd3; e.alu = 1'b1; end
                5'b00101: begin e.rfw = 1'b1; e.rfs = 2'd0; end
                5'b01101: begin e.rfw = 1'b1; e.rfs = 2'd3; end
                5'b00000: begin e.rfw = 1'b1; e.rfs = 2'd1; e.alu = 1'b1; e.mem = 1'b1; end
                5'b01000: begin e.alu = 1'b1; e.mem = 1'b1; e.st = 1'b1; end
                5'b11100: e.kind = K_SYS;
                default:  e.kind = K_ILL;
            endcase
        end
        if (ins[11:7] == 5'd0) e.rfw = 1'b0;
        return e;
    endfunction

    task automatic check_idle();
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_dmem_req", 32'(dreq), 32'd0);
        check_eq("rst_dmem_we", 32'(dwe), 32'd0);
        check_eq("rst_pc_we", 32'(pcw), 32'd0);
        check_eq("rst_pc_sel", 32'(pcs), 32'd0);
        check_eq("rst_rf_we", 32'(rfw), 32'd0);
        check_eq("rst_rf_sel", 32'(rfs), 32'd0);
        check_eq("rst_alu_src", 32'(alu), 32'd0);
        check_eq("rst_fault", 32'(flt), 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        check_eq("rst_ir", ir, 32'd0);
    endtask

    // Release reset; returns at the negedge of the first fetch-request cycle.
    task automatic release_reset();
        imem_rdy = 1'($urandom_range(0, 1));
        imem_data = $urandom;
        reset_n = 1'b1;
        @(negedge clk);
        exp_retired = 32'd0;
        prev_ir = 32'd0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        imem_rdy = 1'($urandom_range(0, 1));
        imem_data = $urandom;
        drdy = 1'($urandom_range(0, 1));
        @(negedge clk);
        @(negedge clk);
        check_idle();
        release_reset();
    endtask

    // Runs one instruction from its first request cycle, checking every cycle.
    task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait,
                             input logic rbc, input int abort_t, output bit halted);
        exp_t e;
        int f, ms, wb, halt_t, stop;
        bit fault_halt, aborted;
        e = ref_model(ins, rbc);
        ms = -1; wb = -1; halt_t = -1; fault_halt = 1'b0; aborted = 1'b0;
        if (fwait >= TIMEOUT) begin
            f = -1; halt_t = TIMEOUT; fault_halt = 1'b1;
        end else begin
            f = fwait + 1;
            if (e.kind == K_ILL) begin
                halt_t = f + 1; fault_halt = 1'b1;
            end else if (e.kind == K_SYS) begin
                halt_t = f + 1;
            end else if (e.mem) begin
                ms = f + 2;
                if (mwait >= TIMEOUT) begin
                    halt_t = ms + TIMEOUT; fault_halt = 1'b1;
                end else begin
                    wb = ms + mwait + 1;
                end
            end else begin
                wb = f + 2;
            end
        end
        stop = (halt_t >= 0) ? halt_t + 3 : wb;
        for (int t = 0; t <= stop; t++) begin
            logic x_ireq, x_dreq, x_alu, x_rfw, x_flt;
            logic [31:0] x_ir;
            x_ireq = (f < 0) ? (t < TIMEOUT) : (t < f);
            x_dreq = (ms >= 0) && (t >= ms) && ((halt_t < 0) ? (t < wb) : (t < halt_t));
            x_alu  = (f >= 0) && (t == f + 1) && (e.kind == K_RUN) && e.alu;
            x_rfw  = (t == wb) && e.rfw;
            x_flt  = fault_halt && (t >= halt_t);
            x_ir   = (f >= 0 && t >= f) ? ins : prev_ir;
            check_eq("imem_req", 32'(imem_req), 32'(x_ireq));
            check_eq("dmem_req", 32'(dreq), 32'(x_dreq));
            check_eq("alu_src", 32'(alu), 32'(x_alu));
            check_eq("pc_we", 32'(pcw), 32'(t == wb));
            check_eq("rf_we", 32'(rfw), 32'(x_rfw));
            check_eq("fault", 32'(flt), 32'(x_flt));
            check_eq("ir", ir, x_ir);
            check_eq("retired", retired, exp_retired);
            if (x_dreq) check_eq("dmem_we", 32'(dwe), 32'(e.st));
            if (t == wb) check_eq("pc_sel", 32'(pcs), 32'(e.pcs));
            if (x_rfw) check_eq("rf_sel", 32'(rfs), 32'(e.rfs));
            imem_rdy = 1'b0;
            imem_data = $urandom;
            drdy = 1'b0;
            bc = rbc;
            if (f >= 0 && t == f - 1) begin
                imem_rdy = 1'b1;
                imem_data = ins;
            end else if (!x_ireq) begin
                imem_rdy = 1'($urandom_range(0, 1));
            end else begin
                imem_rdy = 1'b0;
            end
            if (ms >= 0 && wb >= 0 && t == wb - 1) begin
                drdy = 1'b1;
            end else if (!x_dreq) begin
                drdy = 1'($urandom_range(0, 1));
            end else begin
                drdy = 1'b0;
            end
            if (t == abort_t) begin
                reset_n = 1'b0;
                aborted = 1'b1;
            end
            @(negedge clk);
            if (aborted) break;
        end
        if (aborted || halt_t >= 0) begin
            halted = 1'b1;
        end else begin
            halted = 1'b0;
            exp_retired = exp_retired + 32'd1;
            prev_ir = ins;
        end
    endtask

    initial begin
        logic [4:0]  opcs [0:8];
        logic [31:0] ins;
        bit          h;
        int          fw;
        opcs = '{5'b01100, 5'b00100, 5'b11000, 5'b11011, 5'b11001,
                 5'b00101, 5'b01101, 5'b00000, 5'b01000};
        reset_n = 1'b0; imem_rdy = 1'b0; imem_data = 32'd0; drdy = 1'b0; bc = 1'b0;
        do_reset();

        cur_test = "addi";    run_instr(32'h00500093, 0, 0, 1'b0, -1, h);
        check_eq("addi_retired", retired, 32'd1);
        cur_test = "load_w3"; run_instr(32'h0000A103, 0, 3, 1'b0, -1, h);
        cur_test = "beq_t";   run_instr(32'h00208463, 0, 0, 1'b1, -1, h);
        cur_test = "beq_nt";  run_instr(32'h00208463, 1, 0, 1'b0, -1, h);
        cur_test = "jal";     run_instr(32'h008000EF, 2, 0, 1'b0, -1, h);
        cur_test = "jalr";    run_instr(32'h000080E7, 0, 0, 1'b1, -1, h);
        cur_test = "lui";     run_instr(32'h123450B7, 0, 0, 1'b0, -1, h);
        cur_test = "auipc";   run_instr(32'h00001097, 0, 0, 1'b0, -1, h);
        cur_test = "store";   run_instr(32'h0020A023, 0, 0, 1'b0, -1, h);
        cur_test = "add_x0";  run_instr(32'h00000033, 0, 0, 1'b0, -1, h);
        cur_test = "fetch15"; run_instr(32'h00500093, 15, 0, 1'b0, -1, h);
        cur_test = "mem15";   run_instr(32'h0000A183, 0, 15, 1'b0, -1, h);

        cur_test = "random";
        for (int i = 0; i < 80; i++) begin
            ins = $urandom;
            ins[6:0] = {opcs[$urandom_range(0, 8)], 2'b11};
            if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
            fw = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 4));
            run_instr(ins, fw, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1, h);
        end

        cur_test = "ecall";   run_instr(32'h00000073, 0, 0, 1'b0, -1, h); do_reset();
        cur_test = "all_one"; run_instr(32'hFFFFFFFF, 0, 0, 1'b0, -1, h); do_reset();
        cur_test = "low_bits"; run_instr(32'h00000090, 1, 0, 1'b0, -1, h); do_reset();
        cur_test = "unlisted"; run_instr(32'h0000007F, 0, 0, 1'b0, -1, h); do_reset();
        cur_test = "fetch_to"; run_instr(32'h00500093, 16, 0, 1'b0, -1, h); do_reset();
        cur_test = "mem_to";  run_instr(32'h0000A103, 0, 16, 1'b0, -1, h); do_reset();

        cur_test = "rst_mem";
        run_instr(32'h00500093, 0, 0, 1'b0, -1, h);
        run_instr(32'h0000A103, 0, 20, 1'b0, 3, h);
        check_idle();
        release_reset();
        cur_test = "after_rst"; run_instr(32'h00500093, 0, 0, 1'b0, -1, h);
        check_eq("after_rst_retired", retired, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
